// File: rtl/basic_arith_pkg.sv
// Shared definitions for the basic arithmetic modules.
//   state_e         : sequencing states for the bit-serial datapaths
//   DEFAULT_WIDTH   : default operand width
//   count_width()   : width of a counter that must hold 0..w-1
package basic_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // At least one bit, so that a 1-bit count stays legal for tiny widths.
  function automatic int unsigned count_width(input int unsigned w);
    int unsigned cw;
    cw = $clog2(w);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder slice, purely combinational.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: loads two WIDTH-bit operands, adds them LSB
// first through one full-adder slice over WIDTH cycles, then presents the
// parallel sum and carry out with a one-cycle done pulse.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : request, sampled only in IDLE or DONE
//   a, b      : operands, captured on the accepting edge
//   sum       : registered (a+b) mod 2^WIDTH
//   carry_out : registered carry out of bit WIDTH-1
//   busy      : high while adding
//   done      : one-cycle pulse when sum/carry_out are newly valid
module serial_adder
  import basic_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned       CW   = count_width(WIDTH);
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_cout;

  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    count_d = count_q;
    c_d     = c_q;
    carry_d = carry_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          ps_d    = '0;
          c_d     = 1'b0;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        c_d     = fa_cout;
        ps_d    = {fa_s, ps_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        // Last slice: publish the completed word, including this cycle's bit.
        // The counter is cleared so it never needs to represent WIDTH.
        if (count_q == LAST) begin
          sum_d   = {fa_s, ps_q[WIDTH-1:1]};
          carry_d = fa_cout;
          count_d = '0;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      count_q <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed checks of serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        carry8, busy8, done8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        carry16, busy16, done16;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .sum(sum8), .carry_out(carry8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .sum(sum16), .carry_out(carry16), .busy(busy16), .done(done16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full 8-bit operation from IDLE, with latency and pulse-width checks.
  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    int unsigned n = 0;
    a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    while (!done8 && n < 20) begin
      if (busy8 !== 1'b1) check("op8_busy", {63'd0, busy8}, 64'd1);
      tick();
      n++;
    end
    check("op8_latency", 64'(n), 64'd8);
    check("op8_done", {63'd0, done8}, 64'd1);
    check("op8_busy_at_done", {63'd0, busy8}, 64'd0);
    check("op8_result", {55'd0, carry8, sum8}, 64'(9'(x) + 9'(y)));
    tick();
    check("op8_done_pulse", {63'd0, done8}, 64'd0);
  endtask

  task automatic op16(input logic [15:0] x, input logic [15:0] y);
    int unsigned n = 0;
    a16 = x; b16 = y; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    while (!done16 && n < 40) begin
      tick();
      n++;
    end
    check("op16_latency", 64'(n), 64'd16);
    check("op16_result", {47'd0, carry16, sum16}, 64'(17'(x) + 17'(y)));
    tick();
  endtask

  logic [7:0] va [5] = '{8'h12, 8'hF0, 8'h80, 8'h7F, 8'hC3};
  logic [7:0] vb [5] = '{8'h34, 8'h20, 8'h80, 8'h01, 8'h3C};

  initial begin
    int unsigned cnt;
    logic [8:0]  res;
    logic [8:0]  prev;
    logic [8:0]  exp9;

    // Reset state
    tick(); tick();
    check("rst_sum8", {56'd0, sum8}, 64'd0);
    check("rst_carry8", {63'd0, carry8}, 64'd0);
    check("rst_busy8", {63'd0, busy8}, 64'd0);
    check("rst_done8", {63'd0, done8}, 64'd0);
    rst = 1'b0;
    tick();

    // Basic add, overflow, all-ones
    op8(8'h05, 8'h03);
    check("t1_sum", {56'd0, sum8}, 64'h08);
    op8(8'hFF, 8'h01);
    check("t2_wrap", {55'd0, carry8, sum8}, 64'h100);
    op8(8'hFF, 8'hFF);
    check("t2_ones", {55'd0, carry8, sum8}, 64'h1FE);
    op8(8'h00, 8'h00);

    // start during RUN is ignored; exactly one done pulse
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cnt = 0; res = '0;
    for (int i = 0; i < 14; i++) begin
      if (done8) begin cnt++; res = {carry8, sum8}; end
      tick();
    end
    check("t3_done_count", 64'(cnt), 64'd1);
    check("t3_result", 64'(res), 64'h030);

    // Reset in the 4th RUN cycle aborts the operation
    a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", {63'd0, busy8}, 64'd0);
    check("t4_sum", {56'd0, sum8}, 64'd0);
    check("t4_carry", {63'd0, carry8}, 64'd0);
    check("t4_done", {63'd0, done8}, 64'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) cnt++;
      tick();
    end
    check("t4_no_done", 64'(cnt), 64'd0);

    // Back-to-back with start held high; operands change after each accept
    prev = '0;
    a8 = va[0]; b8 = vb[0]; start8 = 1'b1;
    tick();
    a8 = va[1]; b8 = vb[1];
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        check("t5_busy", {63'd0, busy8}, 64'd1);
        check("t5_hold", {55'd0, carry8, sum8}, 64'(prev));
        tick();
      end
      exp9 = 9'(va[k]) + 9'(vb[k]);
      check("t5_done", {63'd0, done8}, 64'd1);
      check("t5_result", {55'd0, carry8, sum8}, 64'(exp9));
      prev = exp9;
      tick();
      if (k + 2 < 5) begin a8 = va[k+2]; b8 = vb[k+2]; end
    end
    start8 = 1'b0;
    cnt = 0;
    while (!done8 && cnt < 20) begin tick(); cnt++; end
    check("t5_last_latency", 64'(cnt), 64'd8);
    check("t5_last_result", {55'd0, carry8, sum8}, 64'(9'(va[4]) + 9'(vb[4])));
    tick();

    // Pseudo-random operands at both widths, plus 16-bit boundaries
    for (int i = 0; i < 60; i++) op8(8'($urandom), 8'($urandom));
    op16(16'hFFFF, 16'h0001);
    op16(16'hFFFF, 16'hFFFF);
    op16(16'h8000, 16'h7FFF);
    for (int i = 0; i < 60; i++) op16(16'($urandom), 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
